// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the two CPU masters (ibus, dbus) and the shared memory port.
interface cpu_bus_arbiter_if;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_data;
  logic        ibus_stall;
  logic        ibus_error;

  logic [31:0] dbus_address;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byteenable;
  logic [31:0] dbus_data;
  logic        dbus_stall;
  logic        dbus_error;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_data;
  logic        mem_stall;
  logic        mem_error;

  modport slave (
    input  ibus_address, ibus_read,
    input  dbus_address, dbus_read, dbus_write, dbus_wdata, dbus_byteenable,
    input  mem_data, mem_stall, mem_error,
    output ibus_data, ibus_stall, ibus_error,
    output dbus_data, dbus_stall, dbus_error,
    output mem_address, mem_read, mem_write, mem_wdata, mem_byteenable
  );

  modport master (
    output ibus_address, ibus_read,
    output dbus_address, dbus_read, dbus_write, dbus_wdata, dbus_byteenable,
    output mem_data, mem_stall, mem_error,
    input  ibus_data, ibus_stall, ibus_error,
    input  dbus_data, dbus_stall, dbus_error,
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byteenable
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one pipelined memory bus between ibus and dbus; grant, mem_* and stalls are combinational.
// Returning data for a master that lost the following arbitration is parked until it is next unstalled.
module cpu_bus_arbiter #(
  parameter int unsigned IBUS_MAX_WAIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  cpu_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IBUS, OWN_DBUS_RD, OWN_DBUS_WR} owner_e;

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        ihold_vld_q, ihold_vld_d, ihold_err_q, ihold_err_d;
  logic [31:0] ihold_dat_q, ihold_dat_d;
  logic        dhold_vld_q, dhold_vld_d, dhold_err_q, dhold_err_d;
  logic [31:0] dhold_dat_q, dhold_dat_d;

  logic ibus_req, dbus_req, ibus_prio, gnt_i, gnt_d, accept;
  logic ibus_stall_w, dbus_stall_w, ret_i, ret_d;
  logic [31:0] dret_dat;

  always_comb begin : arbitrate
    ibus_req     = bus.ibus_read;
    dbus_req     = bus.dbus_read | bus.dbus_write;
    ibus_prio    = ibus_req & (starve_q >= 4'(IBUS_MAX_WAIT));
    gnt_d        = ~reset & dbus_req & ~ibus_prio;
    gnt_i        = ~reset & ibus_req & ~gnt_d;
    accept       = ~reset & ~bus.mem_stall;
    ibus_stall_w = reset | bus.mem_stall | (ibus_req & ~gnt_i);
    dbus_stall_w = reset | bus.mem_stall | (dbus_req & ~gnt_d);
    ret_i        = accept & (owner_q == OWN_IBUS);
    ret_d        = accept & ((owner_q == OWN_DBUS_RD) | (owner_q == OWN_DBUS_WR));
    // Stores only return an error; keep their data lane quiet.
    dret_dat     = (owner_q == OWN_DBUS_WR) ? 32'h0 : bus.mem_data;
  end

  always_ff @(posedge clock) begin : owner_reg
    if (reset) owner_q <= OWN_NONE;
    else       owner_q <= owner_d;
  end

  always_comb begin : owner_next
    owner_d = owner_q;
    if (accept) begin
      if (gnt_d)      owner_d = bus.dbus_write ? OWN_DBUS_WR : OWN_DBUS_RD;
      else if (gnt_i) owner_d = OWN_IBUS;
      else            owner_d = OWN_NONE;
    end
  end

  always_comb begin : outputs
    bus.mem_read       = gnt_i | (gnt_d & bus.dbus_read);
    bus.mem_write      = gnt_d & bus.dbus_write;
    bus.mem_address    = gnt_d ? bus.dbus_address : bus.ibus_address;
    bus.mem_wdata      = gnt_d ? bus.dbus_wdata : 32'h0;
    bus.mem_byteenable = gnt_d ? bus.dbus_byteenable : 4'b1111;
    bus.ibus_stall     = ibus_stall_w;
    bus.dbus_stall     = dbus_stall_w;
    bus.ibus_data      = 32'h0;
    bus.ibus_error     = 1'b0;
    bus.dbus_data      = 32'h0;
    bus.dbus_error     = 1'b0;
    if (!ibus_stall_w) begin
      if (ihold_vld_q) begin
        bus.ibus_data  = ihold_dat_q;
        bus.ibus_error = ihold_err_q;
      end else if (ret_i) begin
        bus.ibus_data  = bus.mem_data;
        bus.ibus_error = bus.mem_error;
      end
    end
    if (!dbus_stall_w) begin
      if (dhold_vld_q) begin
        bus.dbus_data  = dhold_dat_q;
        bus.dbus_error = dhold_err_q;
      end else if (ret_d) begin
        bus.dbus_data  = dret_dat;
        bus.dbus_error = bus.mem_error;
      end
    end
  end

  always_comb begin : hold_next
    ihold_vld_d = ihold_vld_q;
    ihold_dat_d = ihold_dat_q;
    ihold_err_d = ihold_err_q;
    dhold_vld_d = dhold_vld_q;
    dhold_dat_d = dhold_dat_q;
    dhold_err_d = dhold_err_q;
    if (ret_i && ibus_stall_w) begin
      ihold_vld_d = 1'b1;
      ihold_dat_d = bus.mem_data;
      ihold_err_d = bus.mem_error;
    end else if (ihold_vld_q && !ibus_stall_w) begin
      ihold_vld_d = 1'b0;
    end
    if (ret_d && dbus_stall_w) begin
      dhold_vld_d = 1'b1;
      dhold_dat_d = dret_dat;
      dhold_err_d = bus.mem_error;
    end else if (dhold_vld_q && !dbus_stall_w) begin
      dhold_vld_d = 1'b0;
    end
    starve_d = starve_q;
    if (accept) begin
      if (!ibus_req || gnt_i)             starve_d = 4'd0;
      else if (gnt_d && starve_q != 4'hf) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin : hold_reg
    if (reset) begin
      ihold_vld_q <= 1'b0;
      ihold_dat_q <= 32'h0;
      ihold_err_q <= 1'b0;
      dhold_vld_q <= 1'b0;
      dhold_dat_q <= 32'h0;
      dhold_err_q <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      ihold_vld_q <= ihold_vld_d;
      ihold_dat_q <= ihold_dat_d;
      ihold_err_q <= ihold_err_d;
      dhold_vld_q <= dhold_vld_d;
      dhold_dat_q <= dhold_dat_d;
      dhold_err_q <= dhold_err_d;
      starve_q    <= starve_d;
    end
  end

  // A parked return must be delivered before that master's next return can arrive.
  ihold_no_overrun: assert property (@(posedge clock) disable iff (reset) !(ihold_vld_q && ret_i));
  dhold_no_overrun: assert property (@(posedge clock) disable iff (reset) !(dhold_vld_q && ret_d));
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomized bench: masters and memory follow the private-bus protocol, a scoreboard checks each return.
module tb_cpu_bus_arbiter;
  localparam int MAXW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu_bus_arbiter_if bus();
  cpu_bus_arbiter #(.IBUS_MAX_WAIT(MAXW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        wr;
  } resp_t;

  resp_t iq[$];
  resp_t dq[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h0badf00d;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[4] & a[8];
  endfunction

  // Monitor: expected grant from the priority rules, expected returns from the queues.
  int starve = 0;
  always @(negedge clock) begin
    logic ireq, dreq, egi, egd, eis, eds;
    resp_t r;
    if (reset) begin
      chk("rst_mem_read", bus.mem_read, 1'b0);
      chk("rst_mem_write", bus.mem_write, 1'b0);
      chk("rst_ibus_stall", bus.ibus_stall, 1'b1);
      chk("rst_dbus_stall", bus.dbus_stall, 1'b1);
      chk("rst_ibus_data", bus.ibus_data, 32'h0);
      chk("rst_ibus_error", bus.ibus_error, 1'b0);
      chk("rst_dbus_data", bus.dbus_data, 32'h0);
      chk("rst_dbus_error", bus.dbus_error, 1'b0);
      starve = 0;
    end else begin
      ireq = bus.ibus_read;
      dreq = bus.dbus_read | bus.dbus_write;
      egd  = dreq && !(ireq && starve >= MAXW);
      egi  = ireq && !egd;
      chk("mem_read", bus.mem_read, egi || (egd && bus.dbus_read));
      chk("mem_write", bus.mem_write, egd && bus.dbus_write);
      if (egd) begin
        chk("mem_address_d", bus.mem_address, bus.dbus_address);
        if (bus.dbus_write) begin
          chk("mem_wdata", bus.mem_wdata, bus.dbus_wdata);
          chk("mem_byteenable_d", bus.mem_byteenable, bus.dbus_byteenable);
        end
      end else if (egi) begin
        chk("mem_address_i", bus.mem_address, bus.ibus_address);
        chk("mem_byteenable_i", bus.mem_byteenable, 4'b1111);
      end
      eis = bus.mem_stall || (ireq && !egi);
      eds = bus.mem_stall || (dreq && !egd);
      chk("ibus_stall", bus.ibus_stall, eis);
      chk("dbus_stall", bus.dbus_stall, eds);
      if (!eis && iq.size() > 0) begin
        r = iq.pop_front();
        chk("ibus_data", bus.ibus_data, r.dat);
        chk("ibus_error", bus.ibus_error, r.err);
      end else begin
        chk("ibus_data_idle", bus.ibus_data, 32'h0);
        chk("ibus_error_idle", bus.ibus_error, 1'b0);
      end
      if (!eds && dq.size() > 0) begin
        r = dq.pop_front();
        if (!r.wr) chk("dbus_data", bus.dbus_data, r.dat);
        chk("dbus_error", bus.dbus_error, r.err);
      end else begin
        chk("dbus_data_idle", bus.dbus_data, 32'h0);
        chk("dbus_error_idle", bus.dbus_error, 1'b0);
      end
      if (!bus.mem_stall) begin
        if (!ireq || egi)           starve = 0;
        else if (egd && starve < 15) starve++;
      end
    end
  end

  // Driver state: masters and memory model.
  logic [31:0] ipc = 32'hbfc00000;
  logic        force_st = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic        d_acc_rd;

  task automatic cycle(input int p_i, input int p_d, input int p_w, input int p_stall);
    logic        i_acc, d_acc, d_wr, i_hold, d_hold, mem_acc, mem_adv, rq, wq;
    logic [31:0] ia, da, ma;
    @(negedge clock);
    i_acc   = bus.ibus_read && !bus.ibus_stall;
    d_acc   = (bus.dbus_read || bus.dbus_write) && !bus.dbus_stall;
    d_wr    = bus.dbus_write;
    i_hold  = bus.ibus_read && bus.ibus_stall;
    d_hold  = (bus.dbus_read || bus.dbus_write) && bus.dbus_stall;
    mem_acc = (bus.mem_read || bus.mem_write) && !bus.mem_stall && !reset;
    mem_adv = !bus.mem_stall;
    ia = bus.ibus_address;
    da = bus.dbus_address;
    ma = bus.mem_address;
    @(posedge clock);
    #1;
    if (i_acc) iq.push_back('{dat: word_of(ia), err: err_of(ia), wr: 1'b0});
    if (d_acc) dq.push_back('{dat: (d_wr ? 32'h0 : word_of(da)), err: err_of(da), wr: d_wr});
    d_acc_rd = d_acc && !d_wr;
    if (mem_adv) begin
      m_pend = mem_acc;
      m_addr = ma;
    end
    bus.mem_stall = ($urandom_range(99) < p_stall);
    bus.mem_data  = m_pend ? word_of(m_addr) : $urandom();
    bus.mem_error = m_pend ? err_of(m_addr) : 1'($urandom_range(1));
    if (!i_hold) begin
      if (i_acc) ipc = ipc + 32'd4;
      if (p_i < 100 && $urandom_range(99) < 10) ipc = 32'hbfc00000 | ($urandom() & 32'h00000ffc);
      bus.ibus_read    = ($urandom_range(99) < p_i);
      bus.ibus_address = ipc;
    end
    if (!d_hold) begin
      if (force_st) begin
        bus.dbus_read       = 1'b0;
        bus.dbus_write      = 1'b1;
        bus.dbus_address    = 32'h80000010;
        bus.dbus_wdata      = 32'hdeadbeef;
        bus.dbus_byteenable = 4'b0011;
        force_st            = 1'b0;
      end else begin
        rq = ($urandom_range(99) < p_d);
        wq = rq && ($urandom_range(99) < p_w);
        bus.dbus_read       = rq && !wq;
        bus.dbus_write      = wq;
        bus.dbus_address    = 32'h80000000 | ($urandom() & 32'h0000fffc);
        bus.dbus_wdata      = $urandom();
        bus.dbus_byteenable = 4'($urandom_range(15));
      end
    end
  endtask

  initial begin
    logic got;
    bus.ibus_address    = 32'h0;
    bus.ibus_read       = 1'b0;
    bus.dbus_address    = 32'h0;
    bus.dbus_read       = 1'b0;
    bus.dbus_write      = 1'b0;
    bus.dbus_wdata      = 32'h0;
    bus.dbus_byteenable = 4'h0;
    bus.mem_data        = 32'h0;
    bus.mem_stall       = 1'b0;
    bus.mem_error       = 1'b0;
    d_acc_rd            = 1'b0;

    repeat (3) cycle(0, 0, 0, 0);
    reset = 1'b0;
    repeat (8) cycle(100, 0, 0, 0);       // sequential fetch stream
    force_st = 1'b1;
    repeat (20) cycle(100, 100, 30, 0);   // continuous contention, starvation grants
    repeat (40) cycle(80, 60, 30, 60);    // heavy memory stalls
    repeat (2000) cycle(60, 50, 30, 25);  // mixed random traffic

    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      cycle(0, 100, 0, 0);
      got = d_acc_rd;
    end
    chk("reset_phase_load_accepted", got, 1'b1);
    reset = 1'b1;
    iq.delete();
    dq.delete();
    bus.ibus_read  = 1'b0;
    bus.dbus_read  = 1'b0;
    bus.dbus_write = 1'b0;
    repeat (2) cycle(0, 0, 0, 0);
    reset = 1'b0;
    repeat (4) cycle(0, 0, 0, 0);
    repeat (400) cycle(60, 60, 30, 25);

    repeat (20) cycle(0, 0, 0, 0);
    chk("ibus_queue_drained", iq.size(), 0);
    chk("dbus_queue_drained", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
